vga_timing_prog: RTL

VGA_TIMING_PROG -- requirements
Module: vga_timing_prog

---
 rtl/vga_timing_prog.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_prog.sv
// Programmable VGA/HDMI timing generator: double-buffered timing config, frame-aligned swap.
// Optional 16-bit frame counter on o_frame when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_prog #(
  parameter int CNT_W     = 12,
  parameter int DEF_H_ACT = 1920,
  parameter int DEF_H_SS  = 2008,
  parameter int DEF_H_SL  = 44,
  parameter int DEF_H_TOT = 2200,
  parameter int DEF_V_ACT = 1080,
  parameter int DEF_V_SS  = 1084,
  parameter int DEF_V_SL  = 5,
  parameter int DEF_V_TOT = 1125,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1
) (
  input  logic             i_pclk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_h_act,
  input  logic [CNT_W-1:0] i_h_ss,
  input  logic [CNT_W-1:0] i_h_sl,
  input  logic [CNT_W-1:0] i_h_tot,
  input  logic [CNT_W-1:0] i_v_act,
  input  logic [CNT_W-1:0] i_v_ss,
  input  logic [CNT_W-1:0] i_v_sl,
  input  logic [CNT_W-1:0] i_v_tot,
  input  logic             i_cfg_valid,
  output logic [CNT_W-1:0] o_hcount,
  output logic [CNT_W-1:0] o_vcount,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_hblnk,
  output logic             o_vblnk,
  output logic             o_de,
  output logic             o_sof,
  output logic             o_cfg_pend,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic             o_cfg_err,
  output logic [15:0]      o_frame
`else
  output logic             o_cfg_err
`endif
);

  typedef struct packed {
    logic [CNT_W-1:0] h_act;
    logic [CNT_W-1:0] h_ss;
    logic [CNT_W-1:0] h_sl;
    logic [CNT_W-1:0] h_tot;
    logic [CNT_W-1:0] v_act;
    logic [CNT_W-1:0] v_ss;
    logic [CNT_W-1:0] v_sl;
    logic [CNT_W-1:0] v_tot;
  } timing_t;

  localparam timing_t DEF_TIMING = '{
    h_act: CNT_W'(DEF_H_ACT), h_ss: CNT_W'(DEF_H_SS), h_sl: CNT_W'(DEF_H_SL), h_tot: CNT_W'(DEF_H_TOT),
    v_act: CNT_W'(DEF_V_ACT), v_ss: CNT_W'(DEF_V_SS), v_sl: CNT_W'(DEF_V_SL), v_tot: CNT_W'(DEF_V_TOT)
  };
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] ZERO = '0;

  // Sums are formed one bit wider so that SS+SL cannot wrap.
  function automatic logic axis_ok(logic [CNT_W-1:0] act, logic [CNT_W-1:0] ss,
                                   logic [CNT_W-1:0] sl, logic [CNT_W-1:0] tot);
    return (act < ss) && (({1'b0, ss} + {1'b0, sl}) <= {1'b0, tot}) && (sl != ZERO) && (tot >= TWO);
  endfunction

  function automatic logic in_win(logic [CNT_W-1:0] c, logic [CNT_W-1:0] s, logic [CNT_W-1:0] l);
    return (c >= s) && ({1'b0, c} < ({1'b0, s} + {1'b0, l}));
  endfunction

  timing_t          act_q, shd_q, act_nxt, req;
  logic [CNT_W-1:0] hc_q, vc_q, hc_nxt, vc_nxt;
  logic             run_q, pend_q;
  logic             h_last, v_last, wrap, cfg_ok, accept;
  logic             hb_nxt, vb_nxt, hs_nxt, vs_nxt, sof_nxt;

  // Outputs other than the counters are decoded from the next counter values and the
  // next active set, so after the clock edge they line up with o_hcount/o_vcount.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hc_nxt  = hc_q;
    vc_nxt  = vc_q;
    act_nxt = act_q;
    req     = '{h_act: i_h_act, h_ss: i_h_ss, h_sl: i_h_sl, h_tot: i_h_tot,
                v_act: i_v_act, v_ss: i_v_ss, v_sl: i_v_sl, v_tot: i_v_tot};
    cfg_ok  = axis_ok(req.h_act, req.h_ss, req.h_sl, req.h_tot) &&
              axis_ok(req.v_act, req.v_ss, req.v_sl, req.v_tot);
    accept  = i_cfg_valid && cfg_ok;
    h_last  = (hc_q == act_q.h_tot - ONE);
    v_last  = (vc_q == act_q.v_tot - ONE);
    wrap    = run_q && h_last && v_last;

    // The first cycle after reset holds (0,0) so that frame is shown in full with o_sof.
    if (!run_q) begin
      hc_nxt = ZERO;
      vc_nxt = ZERO;
    end else if (h_last) begin
      hc_nxt = ZERO;
      vc_nxt = v_last ? ZERO : vc_q + ONE;
    end else begin
      hc_nxt = hc_q + ONE;
    end

    if (wrap && pend_q) act_nxt = shd_q;

    hb_nxt  = (hc_nxt >= act_nxt.h_act);
    vb_nxt  = (vc_nxt >= act_nxt.v_act);
    hs_nxt  = in_win(hc_nxt, act_nxt.h_ss, act_nxt.h_sl);
    vs_nxt  = in_win(vc_nxt, act_nxt.v_ss, act_nxt.v_sl);
    sof_nxt = (hc_nxt == ZERO) && (vc_nxt == ZERO);
  end

  always_ff @(posedge i_pclk) begin
    // NOTE: sequential state uses non-blocking assignments only; the old shadow set is
    // read here on the same edge a new config may overwrite it.
    if (i_rst) begin
      hc_q       <= ZERO;
      vc_q       <= ZERO;
      run_q      <= 1'b0;
      act_q      <= DEF_TIMING;
      shd_q      <= DEF_TIMING;
      pend_q     <= 1'b0;
      o_cfg_err  <= 1'b0;
      o_sof      <= 1'b0;
      o_hblnk    <= 1'b0;
      o_vblnk    <= 1'b0;
      o_de       <= 1'b0;
      o_hsync    <= ~HS_POL;
      o_vsync    <= ~VS_POL;
    end else begin
      hc_q      <= hc_nxt;
      vc_q      <= vc_nxt;
      run_q     <= 1'b1;
      act_q     <= act_nxt;
      if (accept) shd_q <= req;
      if (accept)             pend_q <= 1'b1;
      else if (wrap)          pend_q <= 1'b0;
      o_cfg_err <= i_cfg_valid && !cfg_ok;
      o_sof     <= sof_nxt;
      o_hblnk   <= hb_nxt;
      o_vblnk   <= vb_nxt;
      o_de      <= !hb_nxt && !vb_nxt;
      o_hsync   <= HS_POL ? hs_nxt : !hs_nxt;
      o_vsync   <= VS_POL ? vs_nxt : !vs_nxt;
    end
  end

  assign o_hcount   = hc_q;
  assign o_vcount   = vc_q;
  assign o_cfg_pend = pend_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_q;

  // The start-up frame is frame 0; each later start of frame advances the count.
  always_ff @(posedge i_pclk) begin
    if (i_rst)                 frame_q <= 16'd0;
    else if (run_q && sof_nxt) frame_q <= frame_q + 16'd1;
  end

  assign o_frame = frame_q;
`endif

endmodule
